// File: rtl/addr_u_resilient_seq.sv
// addr_u_resilient_seq
//   Digit-serial unsigned adder with duplicate-and-compare fault detection.
//   Two independent lanes compute a+b one DIGIT-wide slice per cycle. Their
//   WIDTH+1-bit results are then compared. On a mismatch the whole addition
//   is retried, up to MAX_RETRY extra attempts. The result is flagged as
//   fault (recovered) or err (never matched). A saturating counter records
//   transactions that raised either flag.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready=1 only while idle
//   a, b                WIDTH-bit unsigned operands, latched at acceptance
//   out_valid/out_ready result handshake; result held until accepted
//   sum                 WIDTH+1-bit result (MSB = carry-out)
//   fault, err          recovered-by-retry / unrecoverable mismatch flags
//   fault_cnt, cnt_clr  saturating count of flagged transactions, sync clear
//   inj_en, inj_mask    fault injection into lane A digit sums during RUN
module addr_u_resilient_seq #(
  parameter int WIDTH     = 8,
  parameter int DIGIT     = 2,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             fault,
  output logic             err,
  output logic [CNT_W-1:0] fault_cnt,
  input  logic             cnt_clr,
  input  logic             inj_en,
  input  logic [DIGIT-1:0] inj_mask
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int DW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int ACCW = WIDTH + 1;
  localparam logic [DW-1:0] LAST_D = DW'(NDIG - 1);
  localparam logic [2:0]    MAXR   = 3'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [DW-1:0]    d;
  logic [2:0]       attempt;
  logic [WIDTH:0]   acc_a, acc_b;
  logic             carry_a, carry_b;

  // Bit offset of the current digit; common to both lanes
  logic [31:0] sh;
  always_comb sh = 32'(d) * 32'(DIGIT);

  // Lane A: digit adder with injection point on the digit sum bits
  logic [DIGIT-1:0] da_a, db_a, s_a, s_a_inj;
  logic             c_a;
  logic [WIDTH:0]   acc_a_nxt;
  always_comb begin
    da_a = DIGIT'(a_q >> sh);
    db_a = DIGIT'(b_q >> sh);
    {c_a, s_a} = {1'b0, da_a} + {1'b0, db_a} + {{DIGIT{1'b0}}, carry_a};
    s_a_inj = inj_en ? (s_a ^ inj_mask) : s_a;
    // Accumulator is cleared per attempt and each slice written once, so OR-in
    acc_a_nxt = acc_a | (ACCW'(s_a_inj) << sh);
    if (d == LAST_D) acc_a_nxt[WIDTH] = c_a;
  end

  // Lane B: independent copy of the digit adder, no injection
  logic [DIGIT-1:0] da_b, db_b, s_b;
  logic             c_b;
  logic [WIDTH:0]   acc_b_nxt;
  always_comb begin
    da_b = DIGIT'(a_q >> sh);
    db_b = DIGIT'(b_q >> sh);
    {c_b, s_b} = {1'b0, da_b} + {1'b0, db_b} + {{DIGIT{1'b0}}, carry_b};
    acc_b_nxt = acc_b | (ACCW'(s_b) << sh);
    if (d == LAST_D) acc_b_nxt[WIDTH] = c_b;
  end

  // Set on the CHECK cycle that will leave for DONE with fault or err raised
  logic flag_set;
  always_comb begin
    flag_set = 1'b0;
    if (state == CHECK)
      flag_set = (acc_a == acc_b) ? (attempt != '0) : (attempt == MAXR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      fault     <= 1'b0;
      err       <= 1'b0;
      fault_cnt <= '0;
      a_q       <= '0;
      b_q       <= '0;
      d         <= '0;
      attempt   <= '0;
      acc_a     <= '0;
      acc_b     <= '0;
      carry_a   <= 1'b0;
      carry_b   <= 1'b0;
    end else begin
      if (cnt_clr)
        fault_cnt <= '0;
      else if (flag_set && fault_cnt != '1)
        fault_cnt <= fault_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            d        <= '0;
            attempt  <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            carry_a  <= 1'b0;
            carry_b  <= 1'b0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc_a   <= acc_a_nxt;
          acc_b   <= acc_b_nxt;
          carry_a <= c_a;
          carry_b <= c_b;
          if (d == LAST_D) begin
            d     <= '0;
            state <= CHECK;
          end else begin
            d <= d + 1'b1;
          end
        end
        CHECK: begin
          if (acc_a == acc_b) begin
            sum   <= acc_a;
            fault <= (attempt != '0);
            err   <= 1'b0;
            state <= DONE;
          end else if (attempt < MAXR) begin
            attempt <= attempt + 1'b1;
            acc_a   <= '0;
            acc_b   <= '0;
            carry_a <= 1'b0;
            carry_b <= 1'b0;
            d       <= '0;
            state   <= RUN;
          end else begin
            sum   <= acc_a;
            fault <= 1'b0;
            err   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE; handoff needs it high
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_u_resilient_seq.sv
// Testbench for addr_u_resilient_seq: driver pushes reference results into a
// scoreboard queue, a separate consumer/monitor pops and checks them.
module tb_addr_u_resilient_seq;

  localparam int W    = 8;
  localparam int DG   = 2;
  localparam int NDIG = W / DG;
  localparam int MR   = 2;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W:0]    sum;
  logic          fault;
  logic          err;
  logic [CW-1:0] fault_cnt;
  logic          cnt_clr = 1'b0;
  logic          inj_en = 1'b0;
  logic [DG-1:0] inj_mask = '0;

  always #5 clk = ~clk;

  addr_u_resilient_seq #(.WIDTH(W), .DIGIT(DG), .MAX_RETRY(MR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .fault(fault), .err(err), .fault_cnt(fault_cnt), .cnt_clr(cnt_clr),
    .inj_en(inj_en), .inj_mask(inj_mask)
  );

  typedef struct {
    logic [W:0]    sum;
    logic          fault;
    logic          err;
    int            lat;
    logic [CW-1:0] cnt;
    int            acc;
    int            stall;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int model_cnt = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  // Reference: an attempt is corrupted when any of its RUN cycles sees a
  // nonzero mask. k = first clean attempt; beyond MR the result is lane A,
  // i.e. the true sum with the mask XORed into every digit slice.
  // mode 0: none, 1: attempt 0 corrupted, 3: attempts 0,1, 2: all attempts
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int mode, input logic [DG-1:0] m);
    exp_t e;
    int k;
    logic [W:0] t;
    logic [W-1:0] mrep;
    t = {1'b0, x} + {1'b0, y};
    mrep = {NDIG{m}};
    case (mode)
      0: k = 0;
      1: k = 1;
      3: k = 2;
      default: k = MR + 1;
    endcase
    e = '{default: 0};
    if (k <= MR) begin
      e.sum = t;
      e.fault = (k != 0);
      e.err = 1'b0;
      e.lat = NDIG + 2 + k * (NDIG + 1);
    end else begin
      e.sum = t ^ {1'b0, mrep};
      e.fault = 1'b0;
      e.err = 1'b1;
      e.lat = NDIG + 2 + MR * (NDIG + 1);
    end
    return e;
  endfunction

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) timeout(nm);
  endtask

  task automatic do_txn(input logic [W-1:0] x, input logic [W-1:0] y, input int mode,
                        input logic [DG-1:0] m_in, input bit clr, input int stall);
    exp_t e;
    int t;
    int k;
    logic [DG-1:0] m;
    m = (mode == 0) ? '0 : m_in;
    wait_idle("idle_wait");
    a = x;
    b = y;
    in_valid = 1'b1;
    inj_mask = m;
    inj_en = (mode != 0);
    e = model(x, y, mode, m);
    if (clr)
      model_cnt = 0;
    else if (e.fault || e.err)
      model_cnt = (model_cnt >= (1 << CW) - 1) ? (1 << CW) - 1 : model_cnt + 1;
    e.cnt = CW'(model_cnt);
    e.acc = cyc + 1;
    e.stall = stall;
    sb.push_back(e);
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 300) begin
      k = cyc - e.acc + 1;
      // Junk on the input side while busy must be ignored
      in_valid = ($urandom_range(0, 3) == 0);
      a = W'($urandom);
      b = W'($urandom);
      case (mode)
        1: inj_en = (k == 1);
        2: inj_en = 1'b1;
        3: inj_en = (k <= 2 * NDIG + 1);
        default: inj_en = ($urandom_range(0, 1) == 1);
      endcase
      cnt_clr = clr && (k == e.lat - 1);
      @(negedge clk);
      t++;
    end
    if (!in_ready) timeout("txn_done_wait");
    in_valid = 1'b0;
    inj_en = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_fault_cnt"}, 32'(fault_cnt), 32'd0);
  endtask

  task automatic reset_mid();
    wait_idle("idle_wait_rst");
    a = W'($urandom);
    b = W'($urandom);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_cnt();
    wait_idle("idle_wait_clr");
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    model_cnt = 0;
    chk("cnt_clear", 32'(fault_cnt), 32'd0);
  endtask

  // Consumer / monitor
  initial begin : mon
    exp_t cur;
    bit seen;
    int st;
    seen = 1'b0;
    st = 0;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
        out_ready = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: sum=0x%0h with empty scoreboard (cycle %0d)", sum, cyc);
            cur = '{default: 0};
          end else begin
            cur = sb.pop_front();
            chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
            chk("sum", 32'(sum), 32'(cur.sum));
            chk("fault", 32'(fault), 32'(cur.fault));
            chk("err", 32'(err), 32'(cur.err));
            chk("fault_cnt", 32'(fault_cnt), 32'(cur.cnt));
            chk("busy_in_ready", 32'(in_ready), 32'd0);
          end
          seen = 1'b1;
          st = cur.stall;
        end else begin
          chk("hold_sum", 32'(sum), 32'(cur.sum));
          chk("hold_fault", 32'(fault), 32'(cur.fault));
          chk("hold_err", 32'(err), 32'(cur.err));
          chk("hold_in_ready", 32'(in_ready), 32'd0);
          if (st > 0) st--;
        end
        out_ready = (st == 0);
      end else begin
        if (seen) chk("ready_after_handoff", 32'(in_ready), 32'd1);
        seen = 1'b0;
        out_ready = 1'b0;
      end
    end
  end

  initial begin : drv
    int t;
    int mode;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    do_txn(8'd100, 8'd27, 0, 2'b00, 1'b0, 0);
    do_txn(8'hFF, 8'hFF, 0, 2'b00, 1'b0, 1);
    do_txn(8'h0F, 8'h01, 1, 2'b01, 1'b0, 0);
    do_txn(8'hA5, 8'h3C, 2, 2'b10, 1'b0, 2);
    do_txn(8'h80, 8'h80, 0, 2'b00, 1'b0, 5);
    do_txn(8'h55, 8'hAB, 3, 2'b11, 1'b0, 0);
    do_txn(8'h01, 8'hFF, 1, 2'b01, 1'b1, 0);
    do_txn(8'hC3, 8'h7E, 2, 2'b11, 1'b0, 3);
    reset_mid();
    do_txn(8'h00, 8'h00, 0, 2'b00, 1'b0, 0);
    do_txn(8'hFF, 8'h01, 0, 2'b00, 1'b0, 0);

    for (int i = 0; i < 120; i++) begin
      mode = $urandom_range(0, 5);
      if (mode > 3) mode = 0;
      do_txn(W'($urandom), W'($urandom), mode, DG'($urandom_range(1, 3)),
             ($urandom_range(0, 15) == 0), $urandom_range(0, 5));
    end

    clear_cnt();
    for (int i = 0; i < 258; i++)
      do_txn(W'($urandom), W'($urandom), 1, DG'($urandom_range(1, 3)), 1'b0, 0);

    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) timeout("scoreboard_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
